// File: rtl/motion_profile_gen.sv
// Trapezoidal velocity-command generator: latches a destination on start and issues one
// velocity command per second tick, braking early enough using an incremental distance sum.
module motion_profile_gen #(
    parameter int c_clkfreq = 100000000,
    parameter int c_acc     = 2,
    parameter int c_vmax    = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [9:0] dest_pos_i,
    input  logic [9:0] pos_i,
    output logic [7:0] vel_o,
    output logic       tick_o,
    output logic [1:0] phase_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int              c_tw     = (c_clkfreq > 1) ? $clog2(c_clkfreq) : 1;
    localparam logic [c_tw-1:0] c_term   = c_tw'(c_clkfreq - 1);
    localparam logic [7:0]      c_acc8   = 8'(c_acc);
    localparam logic [16:0]     c_acc17  = 17'(c_acc);
    localparam logic [16:0]     c_vmax17 = 17'(c_vmax);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_tw-1:0] r_timer;
    logic [c_tw-1:0] w_timer_nxt;
    logic            r_tick;
    logic            w_tick_nxt;
    logic [7:0]      r_vel;
    logic [7:0]      w_vel_nxt;
    logic [15:0]     r_brake;
    logic [15:0]     w_brake_nxt;
    logic [9:0]      r_dest;
    logic [9:0]      w_dest_nxt;
    logic [1:0]      r_phase;
    logic [1:0]      w_phase_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic            r_done;
    logic            w_done_nxt;

    logic [16:0]     w_rem;
    logic [16:0]     w_v17;
    logic [16:0]     w_b17;
    logic [7:0]      w_vel_dec;
    logic            w_can_acc;
    logic            w_can_cruise;

    // Remaining distance and profile decisions, all in 17-bit unsigned so nothing wraps
    always_comb begin
        w_v17     = {9'd0, r_vel};
        w_b17     = {1'b0, r_brake};
        w_vel_dec = r_vel - c_acc8;
        if (pos_i >= r_dest) begin
            w_rem = 17'd0;
        end else begin
            w_rem = {7'd0, r_dest} - {7'd0, pos_i};
        end
        w_can_acc    = ((w_v17 + c_acc17) <= c_vmax17) &&
                       ((w_b17 + (w_v17 << 1) + c_acc17) <= w_rem);
        w_can_cruise = (w_b17 + w_v17) <= w_rem;
    end

    // State, timer, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_tick  <= 1'b0;
            r_vel   <= 8'd0;
            r_brake <= 16'd0;
            r_dest  <= 10'd0;
            r_phase <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_tick  <= w_tick_nxt;
            r_vel   <= w_vel_nxt;
            r_brake <= w_brake_nxt;
            r_dest  <= w_dest_nxt;
            r_phase <= w_phase_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; abort overrides everything, including a coincident tick
    always_comb begin
        w_state_nxt = r_state;
        if (abort_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (r_tick && (w_rem == 17'd0)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Next values for timer, profile datapath and registered outputs
    always_comb begin
        w_timer_nxt = r_timer;
        w_tick_nxt  = 1'b0;
        w_vel_nxt   = r_vel;
        w_brake_nxt = r_brake;
        w_dest_nxt  = r_dest;
        w_phase_nxt = r_phase;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        if (abort_i) begin
            w_timer_nxt = '0;
            w_vel_nxt   = 8'd0;
            w_brake_nxt = 16'd0;
            w_phase_nxt = 2'd0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_timer_nxt = '0;
                    w_vel_nxt   = 8'd0;
                    w_brake_nxt = 16'd0;
                    if (start_i) begin
                        w_dest_nxt  = dest_pos_i;
                        w_phase_nxt = 2'd1;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_phase_nxt = 2'd0;
                        w_busy_nxt  = 1'b0;
                    end
                end
                S_RUN: begin
                    if (r_timer == c_term) begin
                        w_timer_nxt = '0;
                        w_tick_nxt  = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                    // pos_i is only consulted on the tick cycle
                    if (r_tick) begin
                        if (w_rem == 17'd0) begin
                            w_vel_nxt   = 8'd0;
                            w_brake_nxt = 16'd0;
                            w_phase_nxt = 2'd0;
                            w_done_nxt  = 1'b1;
                        end else if (w_can_acc) begin
                            w_brake_nxt = r_brake + {8'd0, r_vel};
                            w_vel_nxt   = r_vel + c_acc8;
                            w_phase_nxt = 2'd1;
                        end else if (w_can_cruise) begin
                            w_phase_nxt = 2'd2;
                        end else begin
                            w_phase_nxt = 2'd3;
                            if (r_vel > c_acc8) begin
                                w_vel_nxt   = w_vel_dec;
                                w_brake_nxt = r_brake - {8'd0, w_vel_dec};
                            end else begin
                                w_vel_nxt   = c_acc8;
                                w_brake_nxt = 16'd0;
                            end
                        end
                    end else begin
                        w_done_nxt = 1'b0;
                    end
                end
                S_DONE: begin
                    w_timer_nxt = '0;
                    w_vel_nxt   = 8'd0;
                    w_brake_nxt = 16'd0;
                    w_phase_nxt = 2'd0;
                    w_busy_nxt  = 1'b0;
                end
                default: begin
                    w_timer_nxt = '0;
                    w_vel_nxt   = 8'd0;
                    w_brake_nxt = 16'd0;
                    w_phase_nxt = 2'd0;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign vel_o   = r_vel;
    assign tick_o  = r_tick;
    assign phase_o = r_phase;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_motion_profile_gen.sv
// Directed table-driven bench for motion_profile_gen acting as the position tracker:
// integrates vel_o into the fed-back position on every tick.
module tb_motion_profile_gen;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic       abort_i;
    logic [9:0] dest_pos_i;
    logic [9:0] pos_i;
    logic [7:0] vel_o;
    logic       tick_o;
    logic [1:0] phase_o;
    logic       busy_o;
    logic       done_o;

    typedef struct {
        int vel;
        int phase;
        int done;
    } vec_t;

    vec_t exp_tab[16];
    int   n_exp;
    int   pos;
    int   n_pass;
    int   n_total;

    motion_profile_gen #(
        .c_clkfreq (10),
        .c_acc     (2),
        .c_vmax    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .dest_pos_i (dest_pos_i),
        .pos_i      (pos_i),
        .vel_o      (vel_o),
        .tick_o     (tick_o),
        .phase_o    (phase_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Accept a start at the next edge and check the cycle after acceptance.
    task automatic do_start(input int dest);
        pos        = 0;
        pos_i      = 10'd0;
        dest_pos_i = 10'(dest);
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("start_busy", int'(busy_o), 1);
        check("start_phase", int'(phase_o), 1);
        check("start_vel", int'(vel_o), 0);
    endtask

    // Wait (bounded) for a tick, then act as tracker: integrate the current command.
    task automatic do_tick(input logic glitch, output int waited);
        logic got;
        got    = 1'b0;
        waited = 0;
        while (waited < 40 && !got) begin
            @(negedge clk);
            waited++;
            if (tick_o) got = 1'b1;
        end
        if (!got) begin
            check("tick_wait", 0, 1);
        end else begin
            pos   = pos + int'(vel_o);
            pos_i = 10'(pos);
            if (glitch) begin
                start_i    = 1'b1;
                dest_pos_i = 10'd100;
            end
        end
    endtask

    // Run the profile held in exp_tab, comparing each post-tick command.
    task automatic run_seq(input int dest, input int exp_pos, input int glitch_at);
        int w;
        do_start(dest);
        for (int k = 0; k < n_exp; k++) begin
            do_tick(k + 1 == glitch_at, w);
            if (k == 0) check("first_tick_latency", w, 10);
            @(negedge clk);
            start_i    = 1'b0;
            dest_pos_i = 10'(dest);
            check($sformatf("vel_t%0d", k + 1), int'(vel_o), exp_tab[k].vel);
            check($sformatf("phase_t%0d", k + 1), int'(phase_o), exp_tab[k].phase);
            check($sformatf("done_t%0d", k + 1), int'(done_o), exp_tab[k].done);
            check($sformatf("tick_pulse_t%0d", k + 1), int'(tick_o), 0);
        end
        check("final_pos", pos, exp_pos);
        @(negedge clk);
        check("post_done_busy", int'(busy_o), 0);
        check("post_done_done", int'(done_o), 0);
    endtask

    task automatic load_dest40();
        n_exp = 9;
        exp_tab[0] = '{2, 1, 0};
        exp_tab[1] = '{4, 1, 0};
        exp_tab[2] = '{6, 1, 0};
        exp_tab[3] = '{8, 1, 0};
        exp_tab[4] = '{8, 2, 0};
        exp_tab[5] = '{6, 3, 0};
        exp_tab[6] = '{4, 3, 0};
        exp_tab[7] = '{2, 3, 0};
        exp_tab[8] = '{0, 0, 1};
    endtask

    initial begin
        int w;
        int saw;
        n_pass     = 0;
        n_total    = 0;
        pos        = 0;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        dest_pos_i = 10'd0;
        pos_i      = 10'd0;
        rst        = 1'b0;
        #12;
        check("rst_vel", int'(vel_o), 0);
        check("rst_tick", int'(tick_o), 0);
        check("rst_phase", int'(phase_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Full trapezoid to 40
        load_dest40();
        run_seq(40, 40, 0);

        // Start pulse with dest 100 during tick 2 must be ignored
        run_seq(40, 40, 2);

        // Short move: accel once, crawl, overshoot to 4
        n_exp = 3;
        exp_tab[0] = '{2, 1, 0};
        exp_tab[1] = '{2, 3, 0};
        exp_tab[2] = '{0, 0, 1};
        run_seq(3, 4, 0);

        // Already at destination: done at first tick, velocity stays 0
        n_exp = 1;
        exp_tab[0] = '{0, 0, 1};
        run_seq(0, 0, 0);

        // Abort on the tick-4 cycle
        do_start(40);
        for (int k = 0; k < 3; k++) begin
            do_tick(1'b0, w);
            @(negedge clk);
        end
        do_tick(1'b0, w);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_vel", int'(vel_o), 0);
        check("abort_busy", int'(busy_o), 0);
        check("abort_phase", int'(phase_o), 0);
        check("abort_done", int'(done_o), 0);
        saw = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done_o || tick_o || busy_o) saw = 1;
        end
        check("abort_quiet", saw, 0);

        // Async reset mid-cruise, then the full profile again
        do_start(40);
        for (int k = 0; k < 5; k++) begin
            do_tick(1'b0, w);
            @(negedge clk);
        end
        check("cruise_phase", int'(phase_o), 2);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_vel", int'(vel_o), 0);
        check("arst_phase", int'(phase_o), 0);
        check("arst_busy", int'(busy_o), 0);
        check("arst_tick", int'(tick_o), 0);
        check("arst_done", int'(done_o), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load_dest40();
        run_seq(40, 40, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
